// File: rtl/gray_conv_arbiter_if.sv
// Handshake bundle between the requesters, the shared
// Gray/binary converter and the result consumer.
interface gray_conv_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 3
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       mode;
    logic [N_REQ*WIDTH-1:0] data_in;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [IDW-1:0]         out_id;

    modport master (
        output req, mode, data_in, out_ready,
        input  grant, busy, out_valid, out_data, out_id
    );

    modport slave (
        input  req, mode, data_in, out_ready,
        output grant, busy, out_valid, out_data, out_id
    );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray<->binary
// converter; results leave tagged with the requester index.
module gray_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 3
) (
    input logic clk,
    input logic rst_n,
    gray_conv_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_last_id;
    logic [WIDTH-1:0] r_op;
    logic             r_mode;
    logic [N_REQ-1:0] r_grant;
    logic             r_valid;
    logic [WIDTH-1:0] r_out;
    logic [IDW-1:0]   r_out_id;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    int               w_idx;
    logic [WIDTH-1:0] w_res;

    // Round-robin pick: first requester after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(r_last_id) + k) % N_REQ;
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(w_idx);
            end
        end
    end

    // XOR network: mode 0 is bin->gray, mode 1 is gray->bin.
    always_comb begin
        w_res = '0;
        if (!r_mode) begin
            w_res = r_op ^ (r_op >> 1);
        end else begin
            w_res[WIDTH-1] = r_op[WIDTH-1];
            for (int i = WIDTH - 2; i >= 0; i--) begin
                w_res[i] = w_res[i+1] ^ r_op[i];
            end
        end
    end

    // Sequencer: grant and latch, convert, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_last_id <= IDW'(N_REQ - 1);
            r_op      <= '0;
            r_mode    <= 1'b0;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_out     <= '0;
            r_out_id  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_grant <= '0;
                    if (w_found) begin
                        r_op      <= bus.data_in[w_win*WIDTH +: WIDTH];
                        r_mode    <= bus.mode[w_win];
                        r_grant   <= N_REQ'(1) << w_win;
                        r_last_id <= w_win;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_grant  <= '0;
                    r_out    <= w_res;
                    r_out_id <= r_last_id;
                    r_valid  <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_out;
    assign bus.out_id    = r_out_id;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed cases plus random
// traffic against a transaction-level reference model.
module tb_gray_conv_arbiter;
    localparam int N = 4;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gray_conv_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus_if ();

    gray_conv_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // reference model state
    int           m_st;
    int           m_last;
    int           m_id;
    int           m_oid;
    logic [N-1:0] m_grant;
    logic         m_valid;
    logic [W-1:0] m_res;
    logic [W-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] b2g(input logic [W-1:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [W-1:0] g2b(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int s = 0; s < W; s++) r = r ^ (v >> s);
        return r;
    endfunction

    function automatic int rr(input logic [N-1:0] r, input int last);
        for (int off = 1; off <= N; off++) begin
            if (r[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] put(input int idx,
                                           input logic [W-1:0] v);
        logic [N*W-1:0] t;
        t = '0;
        t[idx*W +: W] = v;
        return t;
    endfunction

    task automatic model_reset();
        m_st    = 0;
        m_last  = N - 1;
        m_id    = 0;
        m_oid   = 0;
        m_grant = '0;
        m_valid = 1'b0;
        m_res   = '0;
        m_data  = '0;
    endtask

    // one clock edge of transaction-level behaviour
    task automatic model_edge(input logic [N-1:0] r,
                              input logic [N-1:0] md,
                              input logic [N*W-1:0] d,
                              input logic rdy);
        int w;
        if (m_st == 0) begin
            m_grant = '0;
            w = rr(r, m_last);
            if (w >= 0) begin
                m_grant = N'(1) << w;
                m_last  = w;
                m_id    = w;
                m_res   = md[w] ? g2b(d[w*W +: W]) : b2g(d[w*W +: W]);
                m_st    = 1;
            end
        end else if (m_st == 1) begin
            m_grant = '0;
            m_valid = 1'b1;
            m_data  = m_res;
            m_oid   = m_id;
            m_st    = 2;
        end else if (rdy) begin
            m_valid = 1'b0;
            m_st    = 0;
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] md,
                        input logic [N*W-1:0] d, input logic rdy);
        bus_if.req       = r;
        bus_if.mode      = md;
        bus_if.data_in   = d;
        bus_if.out_ready = rdy;
        @(posedge clk);
        model_edge(r, md, d, rdy);
        @(negedge clk);
        chk("grant", 32'(bus_if.grant), 32'(m_grant));
        chk("busy", 32'(bus_if.busy), 32'(m_st != 0));
        chk("valid", 32'(bus_if.out_valid), 32'(m_valid));
        chk("data", 32'(bus_if.out_data), 32'(m_data));
        chk("id", 32'(bus_if.out_id), 32'(m_oid));
    endtask

    task automatic run_one(input int idx, input logic md,
                           input logic [W-1:0] v,
                           output logic [W-1:0] res);
        step(N'(1) << idx, N'(md) << idx, put(idx, v), 1'b1);
        step('0, '0, '0, 1'b1);
        res = bus_if.out_data;
        step('0, '0, '0, 1'b1);
    endtask

    initial begin
        logic [W-1:0] g;
        logic [W-1:0] b;
        logic [N-1:0] gq[$];
        int           tq[$];

        model_reset();
        bus_if.req       = '0;
        bus_if.mode      = '0;
        bus_if.data_in   = '0;
        bus_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(bus_if.grant), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
        rst_n = 1'b1;

        // single bin->gray: 101 -> 111, id 0
        step(4'b0001, 4'b0000, put(0, 3'b101), 1'b1);
        chk("b2g_grant", 32'(bus_if.grant), 32'h1);
        step('0, '0, '0, 1'b1);
        chk("b2g_valid", 32'(bus_if.out_valid), 32'd1);
        chk("b2g_data", 32'(bus_if.out_data), 32'h7);
        chk("b2g_id", 32'(bus_if.out_id), 32'd0);
        step('0, '0, '0, 1'b1);

        // gray->bin on requester 2: 111 -> 101
        run_one(2, 1'b1, 3'b111, b);
        chk("g2b_data", 32'(b), 32'h5);
        chk("g2b_id", 32'(bus_if.out_id), 32'd2);

        // full sweep and round trip
        for (int v = 0; v < 8; v++) begin
            run_one(2, 1'b0, W'(v), g);
            run_one(2, 1'b1, g, b);
            chk("rtrip", 32'(b), 32'(v));
        end

        // fairness, starting from last winner 3
        run_one(3, 1'b0, 3'b010, g);
        for (int c = 0; c < 15; c++) begin
            step(4'b1111, N'($urandom), (N*W)'($urandom), 1'b1);
            if (bus_if.grant != 0) begin
                gq.push_back(bus_if.grant);
                tq.push_back(c);
            end
        end
        chk("fair_n", 32'(gq.size()), 32'd5);
        if (gq.size() == 5) begin
            chk("fair0", 32'(gq[0]), 32'h1);
            chk("fair1", 32'(gq[1]), 32'h2);
            chk("fair2", 32'(gq[2]), 32'h4);
            chk("fair3", 32'(gq[3]), 32'h8);
            chk("fair4", 32'(gq[4]), 32'h1);
            for (int i = 1; i < 5; i++)
                chk("fair_gap", 32'(tq[i] - tq[i-1]), 32'd3);
        end
        step('0, '0, '0, 1'b1);

        // backpressure with req[3] pending
        step(4'b0001, 4'b0000, put(0, 3'b110), 1'b0);
        step(4'b1000, 4'b0000, put(3, 3'b011), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b1000, 4'b0000, put(3, 3'b011), 1'b0);
            chk("bp_valid", 32'(bus_if.out_valid), 32'd1);
            chk("bp_data", 32'(bus_if.out_data), 32'h5);
            chk("bp_grant", 32'(bus_if.grant), 32'd0);
        end
        step(4'b1000, 4'b0000, put(3, 3'b011), 1'b1);
        chk("bp_acc_valid", 32'(bus_if.out_valid), 32'd0);
        step(4'b1000, 4'b0000, put(3, 3'b011), 1'b1);
        chk("bp_grant3", 32'(bus_if.grant), 32'h8);
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);

        // late request while busy
        step(4'b0010, 4'b0000, put(1, 3'b001), 1'b0);
        step(4'b0001, 4'b0000, put(0, 3'b100), 1'b0);
        chk("late_nogr", 32'(bus_if.grant), 32'd0);
        step(4'b0001, 4'b0000, put(0, 3'b100), 1'b0);
        step(4'b0001, 4'b0000, put(0, 3'b100), 1'b1);
        step(4'b0001, 4'b0000, put(0, 3'b100), 1'b1);
        chk("late_grant", 32'(bus_if.grant), 32'h1);
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b0);

        // async reset while in DONE
        chk("pre_rst_valid", 32'(bus_if.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(bus_if.grant), 32'd0);
        chk("arst_busy", 32'(bus_if.busy), 32'd0);
        chk("arst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("arst_data", 32'(bus_if.out_data), 32'd0);
        chk("arst_id", 32'(bus_if.out_id), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0010, 4'b0000, put(1, 3'b011), 1'b1);
        chk("arst_grant1", 32'(bus_if.grant), 32'h2);
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            step(N'($urandom), N'($urandom), (N*W)'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
